state_dump_reader: RTL
======================

STATE_DUMP_READER -- requirements
Module: state_dump_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of register-file and data-memory words.
REQ-002 The block SHALL have parameter NUM_MEM_WORDS, default 32, the number of data-memory words dumped; legal range 1..32.
REQ-003 The block SHALL have these ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- dump_req_i  input  1  start a dump; sampled only in IDLE.
- busy_o  output  1  dump in progress (any state except IDLE).
- cpu_hold_o  output  1  request for the CPU to freeze; equals busy_o.
- done_o  output  1  one-cycle pulse when a dump finishes.
- reg_addr_o  output  5  register-file read address.
- reg_data_i  input  DATA_WIDTH  combinational register-file read data.
- mem_rd_o  output  1  data-memory read strobe.
- mem_addr_o  output  32  data-memory byte address.
- mem_data_i  input  DATA_WIDTH  combinational data-memory read data.
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  consumer accepts the beat.
- out_data_o  output  DATA_WIDTH  dumped word.
- out_tag_o  output  6  beat tag: bit5 = source (0 = register, 1 = memory); bits[4:0] = index.

Function
REQ-004 The block SHALL implement FSM states IDLE, FETCH, SEND and DONE.
REQ-005 In IDLE with dump_req_i=1, the block SHALL load phase=REG and idx=0, then go to FETCH on the next edge.
REQ-006 In FETCH, the block SHALL drive the following and go to SEND:
- reg_addr_o=idx.
- When phase=MEM: mem_rd_o=1 and mem_addr_o={idx,2'b00}, zero-extended.
- At the edge: out_data_o captured from reg_data_i (phase REG) or mem_data_i (phase MEM); out_tag_o={phase,idx}.
REQ-007 In SEND, the block SHALL hold out_valid_o=1 and keep out_data_o and out_tag_o stable until out_ready_i=1.
REQ-008 On a SEND handshake, the block SHALL step as follows:
- Phase REG, idx<31: idx+1, go to FETCH.
- Phase REG, idx=31: phase=MEM, idx=0, go to FETCH.
- Phase MEM, idx<NUM_MEM_WORDS-1: idx+1, go to FETCH.
- Phase MEM, idx=NUM_MEM_WORDS-1: go to DONE.
REQ-009 In DONE, the block SHALL assert done_o=1 for exactly one cycle and return to IDLE.
REQ-010 The block SHALL emit beats in the fixed order R0..R31, then M0..M(NUM_MEM_WORDS-1), i.e. 32+NUM_MEM_WORDS beats total.
REQ-011 Beat timing SHALL be as follows:
- Throughput: one beat per 2 cycles when out_ready_i is held 1.
- The first FETCH occurs in the cycle after dump_req_i is sampled.
REQ-012 The block SHALL ignore dump_req_i outside IDLE; no restart or queueing.
REQ-013 The block SHALL ignore out_ready_i outside SEND.
REQ-014 Indefinite backpressure (out_ready_i=0) SHALL stall in SEND with no data change, no timeout and no lost beat.
REQ-015 mem_rd_o SHALL be 0 except in FETCH with phase=MEM, and out_valid_o SHALL be 0 except in SEND.
REQ-016 busy_o and cpu_hold_o SHALL be 1 in FETCH, SEND and DONE, and 0 in IDLE.
REQ-017 The block SHALL never write the register file or memory; it is a pure reader.

Reset
REQ-018 With rst_i=1, the block SHALL immediately enter IDLE regardless of clk_i, with these values:
- phase=REG, idx=0.
- busy_o=0, cpu_hold_o=0, done_o=0, mem_rd_o=0, out_valid_o=0.
- out_data_o=0, out_tag_o=0, reg_addr_o=0, mem_addr_o=0.
REQ-019 Reset mid-dump SHALL abort the dump without a done_o pulse; the next dump_req_i after reset deasserts restarts from R0.

Verification
REQ-020 Reset check: assert rst_i mid-cycle -> all outputs 0 before the next clk_i edge.
REQ-021 Full dump, out_ready_i=1, default parameters, registers Rk=k+100 and memory Mk=k*4:
- dump_req_i sampled at edge 0.
- 64 beats, beat k in SEND cycle 2k+2.
- First beat tag 0x00, data 100; beat 32 tag 0x20, data 0; last beat tag 0x3F, data 124.
- done_o high in cycle 129 only; busy_o low from cycle 130.
REQ-022 Backpressure: out_ready_i=0 for 10 cycles during beat R5 (tag 0x05, data 105) -> out_valid_o held, data and tag unchanged; accepted on the first cycle out_ready_i=1, then R6 follows.
REQ-023 Request while busy: pulse dump_req_i at beat R10 -> ignored; exactly 64 beats and one done_o pulse.
REQ-024 Address check: during FETCH of M31, mem_addr_o=0x7C and mem_rd_o=1; during register FETCHes, mem_rd_o=0.
REQ-025 Abort: assert rst_i during beat M3 -> IDLE, no done_o; a new request yields 64 beats starting at R0.

Source files
------------

// File: rtl/state_dump_reader.sv
// Debug state dump engine: freezes the CPU, then streams all 32 register-file
// words followed by NUM_MEM_WORDS data-memory words over a valid/ready port.
module state_dump_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_MEM_WORDS = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dump_req_i,
    output logic                  busy_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic [4:0]            reg_addr_o,
    input  logic [DATA_WIDTH-1:0] reg_data_i,
    output logic                  mem_rd_o,
    output logic [31:0]           mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [5:0]            out_tag_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    localparam logic [4:0] MEM_LAST = 5'(NUM_MEM_WORDS - 1);

    state_t     state;
    logic       phase_mem;   // 0 = register file, 1 = data memory
    logic [4:0] idx;

    logic       next_phase_mem;
    logic [4:0] next_idx;
    logic       last_beat;

    assign cpu_hold_o = busy_o;

    // Position of the beat after the current one in the R0..R31, M0..Mn order
    always_comb begin
        next_phase_mem = phase_mem;
        next_idx       = idx + 5'd1;
        last_beat      = phase_mem && (idx == MEM_LAST);
        if (!phase_mem && (idx == 5'd31)) begin
            next_phase_mem = 1'b1;
            next_idx       = '0;
        end
    end

    // Dump sequencer; every output is registered and set on entry to the state that owns it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            phase_mem   <= 1'b0;
            idx         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            reg_addr_o  <= '0;
            mem_rd_o    <= 1'b0;
            mem_addr_o  <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_tag_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (dump_req_i) begin
                        state      <= FETCH;
                        phase_mem  <= 1'b0;
                        idx        <= '0;
                        busy_o     <= 1'b1;
                        reg_addr_o <= '0;
                        mem_rd_o   <= 1'b0;
                        mem_addr_o <= '0;
                    end
                end
                FETCH: begin
                    state       <= SEND;
                    out_data_o  <= phase_mem ? mem_data_i : reg_data_i;
                    out_tag_o   <= {phase_mem, idx};
                    mem_rd_o    <= 1'b0;
                    out_valid_o <= 1'b1;
                end
                SEND: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (last_beat) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            phase_mem  <= next_phase_mem;
                            idx        <= next_idx;
                            reg_addr_o <= next_idx;
                            mem_rd_o   <= next_phase_mem;
                            mem_addr_o <= next_phase_mem ? {25'd0, next_idx, 2'b00} : '0;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
